serial_word_collector: RTL



---
 rtl/serial_word_collector_pkg.sv | 13 +
 rtl/serial_word_collector_if.sv | 14 +
 rtl/serial_word_collector_counter.sv | 28 ++
 rtl/serial_word_collector.sv | 86 ++++++++
 4 files changed

// File: rtl/serial_word_collector_pkg.sv
// Shared definitions for the serial word collector: default word length,
// bit-counter width and the two-state frame FSM encoding.
package serial_word_collector_pkg;

   localparam int DEFAULT_WIDTH = 5;
   localparam int COUNT_W       = 3;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

endpackage

// File: rtl/serial_word_collector_if.sv
// Word handshake between the collector (master) and its consumer (slave).
interface serial_word_collector_if
   import serial_word_collector_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH)
   ();

   logic [WIDTH-1:0] word;
   logic             valid;
   logic             ready;

   modport master (output word, output valid, input ready);
   modport slave  (input word, input valid, output ready);

endinterface

// File: rtl/serial_word_collector_counter.sv
// Modulo-WIDTH bit counter; wrap flags the sample that completes a word.
module modulo_bit_counter
   import serial_word_collector_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH)
   (
   input  logic               clock,
   input  logic               clear,
   input  logic               restart,
   input  logic               enable,
   output logic [COUNT_W-1:0] count,
   output logic               wrap
   );

   localparam logic [COUNT_W-1:0] LAST = COUNT_W'(WIDTH - 1);

   assign wrap = enable && (count == LAST);

   always_ff @(posedge clock) begin
      if (clear) begin
         count <= '0;
      end else if (restart || wrap) begin
         count <= '0;
      end else if (enable) begin
         count <= count + COUNT_W'(1);
      end
   end

endmodule

// File: rtl/serial_word_collector.sv
// Reassembles LSB-first serial words from the upstream shift register and
// offers them on a valid/ready handshake with a sticky overrun flag.
module serial_word_collector
   import serial_word_collector_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH)
   (
   input  logic                      clock,
   input  logic                      clear,
   input  logic                      serial_in,
   input  logic                      start,
   input  logic                      enable,
   input  logic                      continuous,
   serial_word_collector_if.master   bus,
   output logic                      overrun,
   output logic                      busy,
   output logic [COUNT_W-1:0]        bit_count
   );

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] new_word;
   logic             sample;
   logic             wrap;
   logic             complete;

   assign sample   = (state == COLLECT) && enable;
   assign new_word = {serial_in, sr[WIDTH-1:1]};
   // A start on the completing edge discards the frame instead of finishing it.
   assign complete = wrap && !start;
   assign busy     = (state == COLLECT);

   modulo_bit_counter #(.WIDTH(WIDTH)) counter_inst (
      .clock   (clock),
      .clear   (clear),
      .restart (start),
      .enable  (sample),
      .count   (bit_count),
      .wrap    (wrap)
   );

   always_comb begin
      state_next = state;
      if (start) begin
         state_next = COLLECT;
      end else if (complete) begin
         state_next = continuous ? COLLECT : IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         sr        <= '0;
         bus.word  <= '0;
         bus.valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (start) begin
            sr <= '0;
         end else if (sample) begin
            sr <= new_word;
         end

         // An unconsumed word is never overwritten; the new one is dropped.
         if (complete) begin
            if (!bus.valid || bus.ready) begin
               bus.word  <= new_word;
               bus.valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (bus.valid && bus.ready) begin
            bus.valid <= 1'b0;
         end
      end
   end

endmodule
